stats_counters: RTL and testbench
=================================

# stats_counters

Parametrised performance-statistics collector that sits beside the pipeline in the simulation top. It accumulates per-cycle event increments (retires, cache misses, stalls, flushes, ...) from `NEVT` channels plus a free-running cycle counter. It captures all counters atomically into a shadow bank on request or on a programmable window boundary, and serves shadow reads over a request/done handshake. Sticky overflow flags and freeze/clear controls support per-phase measurement without stopping the core.

## Interface
Parameters:
- `NEVT`, 8: number of event channels; counter index `NEVT` is the cycle counter.
- `CNTW`, 48: counter and shadow width in bits.
- `INCW`, 2: per-channel increment width; each channel adds 0..2^INCW-1 per cycle.
- `WINW`, 32: window-length width.

Ports (reset is asynchronous, active-high; one clock):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `evt_inc`  in  NEVT×INCW  per-channel increment for this cycle.
- `ctl_clear`  in  1  one-cycle pulse: zero live counters and overflow flags.
- `ctl_freeze`  in  1  level: live counters and window counter hold.
- `win_len`  in  WINW  auto-snapshot period in cycles; 0 disables.
- `snap_rqst`  in  1  snapshot request level.
- `snap_done`  out  1  one-cycle pulse: shadow bank updated.
- `win_evt`  out  1  one-cycle pulse: window boundary reached.
- `rd_rqst`  in  1  shadow read request.
- `rd_idx`  in  $clog2(NEVT+1)  shadow index to read.
- `rd_done`  out  1  read data valid, one cycle.
- `rd_data`  out  CNTW  shadow value.
- `ovf`  out  NEVT+1  sticky per-counter overflow flags (live).

## Operation
Live counters:
- Each enabled cycle, `cnt[i] += evt_inc[i]` and `cnt[NEVT] += 1`.
- A cycle is enabled when `ctl_freeze` = 0 and `ctl_clear` = 0.
- Width rule: the sum is CNTW+1 bits. A carry-out sets `ovf[i]`, which stays set until `ctl_clear` or reset.
- `ctl_clear` wins over increments: all counters and `ovf` are 0 next cycle. The window counter also restarts at 0.

Window:
- When `win_len` ≠ 0 and the cycle is enabled, `wcnt` increments.
- When `wcnt == win_len-1`, `wcnt` → 0, `win_evt` pulses, and `auto_pend` is set.
- Lowering `win_len` below `wcnt` restarts `wcnt` at 0 the next cycle.

Snapshot FSM (IDLE, CAPT, WAIT):
- IDLE → CAPT when `snap_rqst` or `auto_pend`. The shadow bank loads all NEVT+1 live values from the end of that same cycle, so the capture is atomic. The live value includes that cycle's increment.
- CAPT: `snap_done` = 1 for one cycle; `auto_pend` is cleared.
  - → WAIT if `snap_rqst` is still high.
  - → IDLE otherwise.
- WAIT: hold until `snap_rqst` = 0, then → IDLE. A held request therefore yields exactly one snapshot.
- A window expiry outside IDLE leaves `auto_pend` set. It is serviced on the next IDLE, and multiple expiries coalesce into one snapshot.
- Snapshot and `ctl_clear` in the same cycle: the shadow receives the pre-clear values, and the live counters go to 0.

Read port:
- `rd_rqst` is sampled every cycle, independent of FSM state.
- One cycle later, `rd_done` = 1 and `rd_data` = `shadow[rd_idx]`.
- An index greater than NEVT returns 0 with `rd_done` = 1.
- A read in the same cycle as a capture returns the old shadow value.

## Timing
- Reset values: all counters, shadow, `ovf`, `wcnt`, and `auto_pend` = 0. FSM = IDLE. `snap_done`, `win_evt`, `rd_done`, and `rd_data` = 0.
- Reset is asynchronous. Mid-snapshot or mid-read, it aborts the operation without producing a done pulse.
- Snapshot latency: `snap_done` is high the cycle after the request is first seen in IDLE. The minimum request-to-request spacing is 2 cycles.
- Read latency: 1 cycle, fully pipelined, one read per cycle.
- All outputs are registered.

## Configuration
- `STATS_SATURATE_EN`:
  - Defined: counters that overflow stick at all-ones (2^CNTW-1), and `ovf` is still set.
  - Undefined: counters wrap modulo 2^CNTW.

## Test plan
- Reset, then `evt_inc[0]` = 1 for 10 cycles, then `snap_rqst` pulse → `snap_done` one cycle later; read idx 0 → 10 and idx NEVT → cycle count since reset, with `rd_done` 1 cycle after `rd_rqst`.
- `win_len` = 5, no request → `win_evt` and `snap_done` every 5 cycles; shadow cycle counter reads 5, 10, 15.
- `snap_rqst` held high 6 cycles → exactly one `snap_done`; a window expiry during WAIT → a second snapshot immediately after WAIT exits.
- `ctl_clear` together with `snap_rqst` and counter 0 = 7 → shadow 0 = 7, live 0 = 0, `ovf` = 0; `ctl_freeze` for 4 cycles → counters unchanged.
- CNTW = 8, `evt_inc[1]` = 3 from 254:
  - without the macro → wraps to 1, `ovf[1]` = 1;
  - with `STATS_SATURATE_EN` → 255, `ovf[1]` = 1.
- Assert `rst` during CAPT → no `snap_done`; all outputs 0 asynchronously.

Source files
------------

// File: rtl/stats_counters.sv
// stats_counters
//   Performance-statistics collector. Accumulates per-cycle event increments
//   from NEVT channels plus a free-running cycle counter (index NEVT). On a
//   snapshot request or a programmable window boundary it copies every live
//   counter into a shadow bank in a single cycle. The shadow bank is read
//   back through a one-cycle, fully pipelined request/done port.
//
//   Parameters: NEVT (event channels), CNTW (counter width),
//               INCW (per-channel increment width), WINW (window length width)
//
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     evt_inc       NEVT packed INCW-bit increments for this cycle
//     ctl_clear     pulse: zero live counters, overflow flags and window count
//     ctl_freeze    level: live counters and window counter hold
//     win_len       auto-snapshot period in cycles, 0 disables
//     snap_rqst     snapshot request level
//     snap_done     pulse: shadow bank updated
//     win_evt       pulse: window boundary reached
//     rd_rqst       shadow read request
//     rd_idx        shadow index (> NEVT reads as 0)
//     rd_done       read data valid
//     rd_data       shadow value
//     ovf           sticky per-counter overflow flags
//
//   Build option: STATS_SATURATE_EN -- when defined, overflowing counters
//   stick at all-ones instead of wrapping. ovf is set in both builds.

module stats_counters #(
  parameter int unsigned NEVT = 8,
  parameter int unsigned CNTW = 48,
  parameter int unsigned INCW = 2,
  parameter int unsigned WINW = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NEVT*INCW-1:0]      evt_inc,
  input  logic                      ctl_clear,
  input  logic                      ctl_freeze,
  input  logic [WINW-1:0]           win_len,
  input  logic                      snap_rqst,
  output logic                      snap_done,
  output logic                      win_evt,
  input  logic                      rd_rqst,
  input  logic [$clog2(NEVT+1)-1:0] rd_idx,
  output logic                      rd_done,
  output logic [CNTW-1:0]           rd_data,
  output logic [NEVT:0]             ovf
);

  localparam int unsigned NCNT = NEVT + 1;
  localparam int unsigned IDXW = $clog2(NEVT + 1);
  localparam int unsigned SUMW = CNTW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [CNTW-1:0] r_cnt    [NCNT];
  logic [CNTW-1:0] r_shadow [NCNT];
  logic [NCNT-1:0] r_ovf;
  logic [WINW-1:0] r_wcnt;
  logic            r_auto_pend;
  state_t          r_state;
  logic            r_snap_done;
  logic            r_win_evt;
  logic            r_rd_done;
  logic [CNTW-1:0] r_rd_data;

  // ---------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------
  logic            w_en;
  logic [CNTW-1:0] w_upd    [NCNT];
  logic [NCNT-1:0] w_ovf_set;
  logic            w_win_on;
  logic            w_win_last;
  logic            w_win_hit;
  logic            w_auto;
  state_t          w_state_nxt;
  logic            w_capture;
  logic [CNTW-1:0] w_rd_val;

  // Counting is suppressed by freeze and by clear (clear wins over increments)
  assign w_en = ~ctl_freeze & ~ctl_clear;

  // Per-counter next value; w_upd is also the value the shadow captures,
  // so a snapshot sees this cycle's increment but never the clear.
  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    logic [INCW-1:0] w_inc;
    logic [SUMW-1:0] w_sum;
    logic            w_carry;
    logic [CNTW-1:0] w_val;

    if (g < NEVT) begin : g_evt
      assign w_inc = evt_inc[g*INCW +: INCW];
    end else begin : g_cyc
      assign w_inc = INCW'(1);
    end

    assign w_sum   = {1'b0, r_cnt[g]} + SUMW'(w_inc);
    assign w_carry = w_sum[CNTW];

`ifdef STATS_SATURATE_EN
    assign w_val = w_carry ? {CNTW{1'b1}} : w_sum[CNTW-1:0];
`else
    assign w_val = w_sum[CNTW-1:0];
`endif

    assign w_upd[g]     = w_en ? w_val : r_cnt[g];
    assign w_ovf_set[g] = w_en & w_carry;
  end

  // Live counters and sticky overflow flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCNT; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else if (ctl_clear) begin
      for (int i = 0; i < NCNT; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) r_cnt[i] <= w_upd[i];
      r_ovf <= r_ovf | w_ovf_set;
    end
  end

  // ---------------------------------------------------------------------
  // Window counter
  // ---------------------------------------------------------------------
  assign w_win_on   = (win_len != '0);
  assign w_win_last = (r_wcnt == win_len - WINW'(1));
  assign w_win_hit  = w_en & w_win_on & w_win_last;

  // A window length shrunk to or below the running count restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (ctl_clear || !w_win_on || (r_wcnt >= win_len)) begin
      r_wcnt <= '0;
    end else if (w_en) begin
      r_wcnt <= w_win_last ? '0 : r_wcnt + WINW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_win_evt <= 1'b0;
    else     r_win_evt <= w_win_hit;
  end

  // An expiry in IDLE is captured on the same edge; otherwise it waits here.
  // Several expiries while busy coalesce into one pending snapshot.
  assign w_auto = r_auto_pend | w_win_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_auto_pend <= 1'b0;
    else if (w_capture) r_auto_pend <= 1'b0;
    else if (w_win_hit) r_auto_pend <= 1'b1;
  end

  // ---------------------------------------------------------------------
  // Snapshot FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // WAIT absorbs a held request so it produces only one snapshot
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (snap_rqst || w_auto) w_state_nxt = S_CAPT;
      S_CAPT:  w_state_nxt = snap_rqst ? S_WAIT : S_IDLE;
      S_WAIT:  if (!snap_rqst) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    case (r_state)
      S_IDLE:  w_capture = snap_rqst | w_auto;
      default: w_capture = 1'b0;
    endcase
  end

  // Shadow bank loads every counter on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCNT; i++) r_shadow[i] <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < NCNT; i++) r_shadow[i] <= w_upd[i];
    end
  end

  // snap_done is high during CAPT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_snap_done <= 1'b0;
    else     r_snap_done <= w_capture;
  end

  // ---------------------------------------------------------------------
  // Read port: index decode falls through to 0 for out-of-range indices
  // ---------------------------------------------------------------------
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_idx == IDXW'(i)) w_rd_val = r_shadow[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_done <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_done <= rd_rqst;
      r_rd_data <= rd_rqst ? w_rd_val : '0;
    end
  end

  assign snap_done = r_snap_done;
  assign win_evt   = r_win_evt;
  assign rd_done   = r_rd_done;
  assign rd_data   = r_rd_data;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_stats_counters.sv
// Self-checking bench for stats_counters: directed phases from the test plan
// followed by a randomized phase, all compared against a behavioural model
// that tracks true event totals and derives wrapped/saturated views from them.

module tb_stats_counters;

  localparam int unsigned NEVT = 4;
  localparam int unsigned CNTW = 8;
  localparam int unsigned INCW = 2;
  localparam int unsigned WINW = 8;
  localparam int unsigned NCNT = NEVT + 1;
  localparam int unsigned IDXW = $clog2(NEVT + 1);
  localparam int unsigned EW   = NEVT * INCW;
  localparam longint      LIM  = longint'(1) << CNTW;

  logic            clk = 1'b0;
  logic            rst;
  logic [EW-1:0]   evt_inc;
  logic            ctl_clear;
  logic            ctl_freeze;
  logic [WINW-1:0] win_len;
  logic            snap_rqst;
  logic            snap_done;
  logic            win_evt;
  logic            rd_rqst;
  logic [IDXW-1:0] rd_idx;
  logic            rd_done;
  logic [CNTW-1:0] rd_data;
  logic [NEVT:0]   ovf;

  always #5 clk = ~clk;

  stats_counters #(
    .NEVT(NEVT), .CNTW(CNTW), .INCW(INCW), .WINW(WINW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .evt_inc   (evt_inc),
    .ctl_clear (ctl_clear),
    .ctl_freeze(ctl_freeze),
    .win_len   (win_len),
    .snap_rqst (snap_rqst),
    .snap_done (snap_done),
    .win_evt   (win_evt),
    .rd_rqst   (rd_rqst),
    .rd_idx    (rd_idx),
    .rd_done   (rd_done),
    .rd_data   (rd_data),
    .ovf       (ovf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: true totals since last clear, shadow snapshot, window
  // position, pending auto snapshot and snapshot-engine phase
  longint          m_tot [NCNT];
  logic [CNTW-1:0] m_shadow [NCNT];
  int              m_wcnt;
  bit              m_pend;
  int              m_phase;   // 0 ready, 1 just captured, 2 request still held

  logic            e_snap, e_win, e_rdd;
  logic [CNTW-1:0] e_rdata;
  logic [NEVT:0]   e_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNTW-1:0] view(input longint t);
`ifdef STATS_SATURATE_EN
    if (t >= LIM) return {CNTW{1'b1}};
    return CNTW'(t);
`else
    return CNTW'(t % LIM);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCNT; i++) begin
      m_tot[i]    = 0;
      m_shadow[i] = '0;
    end
    m_wcnt  = 0;
    m_pend  = 0;
    m_phase = 0;
  endtask

  // Apply one clock edge worth of specification rules to the model
  task automatic model_update();
    bit en, hit, take;
    int wl;
    e_rdd   = rd_rqst;
    e_rdata = '0;
    if (rd_rqst && int'(rd_idx) <= int'(NEVT)) e_rdata = m_shadow[rd_idx];

    en = !ctl_freeze && !ctl_clear;
    if (en) begin
      for (int i = 0; i < NEVT; i++) m_tot[i] += longint'(evt_inc[i*INCW +: INCW]);
      m_tot[NEVT] += 1;
    end

    wl  = int'(win_len);
    hit = 0;
    if (ctl_clear || wl == 0 || m_wcnt >= wl) m_wcnt = 0;
    else if (en) begin
      m_wcnt++;
      if (m_wcnt == wl) begin
        hit    = 1;
        m_wcnt = 0;
      end
    end

    take   = (m_phase == 0) && (snap_rqst || m_pend || hit);
    e_snap = take;
    if (take) begin
      for (int i = 0; i < NCNT; i++) m_shadow[i] = view(m_tot[i]);
      m_pend  = 0;
      m_phase = 1;
    end else begin
      if (hit) m_pend = 1;
      if (m_phase == 1)                    m_phase = snap_rqst ? 2 : 0;
      else if (m_phase == 2 && !snap_rqst) m_phase = 0;
    end

    if (ctl_clear) for (int i = 0; i < NCNT; i++) m_tot[i] = 0;
    e_win = hit;
    for (int i = 0; i < NCNT; i++) e_ovf[i] = (m_tot[i] >= LIM);
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("snap_done", 64'(snap_done), 64'(e_snap));
    check("win_evt",   64'(win_evt),   64'(e_win));
    check("rd_done",   64'(rd_done),   64'(e_rdd));
    check("rd_data",   64'(rd_data),   64'(e_rdata));
    check("ovf",       64'(ovf),       64'(e_ovf));
  endtask

  task automatic idle_inputs();
    evt_inc    = '0;
    ctl_clear  = 1'b0;
    ctl_freeze = 1'b0;
    snap_rqst  = 1'b0;
    rd_rqst    = 1'b0;
    rd_idx     = '0;
  endtask

  task automatic read_all();
    for (int i = 0; i <= int'(NEVT) + 1; i++) begin
      rd_rqst = 1'b1;
      rd_idx  = IDXW'(i);
      step();
    end
    rd_rqst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_snap_done"}, 64'(snap_done), 64'(0));
    check({tag, "_win_evt"},   64'(win_evt),   64'(0));
    check({tag, "_rd_done"},   64'(rd_done),   64'(0));
    check({tag, "_rd_data"},   64'(rd_data),   64'(0));
    check({tag, "_ovf"},       64'(ovf),       64'(0));
  endtask

  int  n_snap;
  bit  hold;

  initial begin
    rst = 1'b1;
    idle_inputs();
    win_len = '0;
    model_reset();
    #22;
    check_outputs_zero("reset");
    rst = 1'b0;

    // 10 cycles of channel 0 = 1, then a one-cycle snapshot request
    evt_inc = EW'(1);
    for (int i = 0; i < 10; i++) step();
    evt_inc   = '0;
    snap_rqst = 1'b1;
    step();
    check("first_snap_done", 64'(snap_done), 64'(1));
    snap_rqst = 1'b0;
    rd_rqst = 1'b1; rd_idx = IDXW'(0);
    step();
    check("shadow0_is_10", 64'(rd_data), 64'(10));
    rd_idx = IDXW'(NEVT);
    step();
    check("shadow_cycles_is_11", 64'(rd_data), 64'(11));
    rd_rqst = 1'b0;
    read_all();

    // Window of 5 with no explicit request
    ctl_clear = 1'b1; win_len = WINW'(5);
    step();
    ctl_clear = 1'b0;
    rd_rqst = 1'b1; rd_idx = IDXW'(NEVT);
    n_snap = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (snap_done) n_snap++;
    end
    check("window_snap_count", 64'(n_snap), 64'(3));
    check("window_cycles_15", 64'(rd_data), 64'(15));
    rd_rqst = 1'b0;

    // Held request: one snapshot, expiry during WAIT serviced afterwards
    win_len = '0;
    for (int i = 0; i < 3; i++) step();
    ctl_clear = 1'b1;
    step();
    ctl_clear = 1'b0;
    win_len   = WINW'(3);
    snap_rqst = 1'b1;
    n_snap = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (snap_done) n_snap++;
    end
    check("held_rqst_one_snap", 64'(n_snap), 64'(1));
    snap_rqst = 1'b0;
    win_len   = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (snap_done) n_snap++;
    end
    check("pending_after_wait", 64'(n_snap), 64'(2));

    // Clear together with snapshot, then freeze
    ctl_clear = 1'b1;
    step();
    ctl_clear = 1'b0;
    evt_inc = EW'(1);
    for (int i = 0; i < 7; i++) step();
    evt_inc   = '0;
    snap_rqst = 1'b1; ctl_clear = 1'b1;
    step();
    snap_rqst = 1'b0; ctl_clear = 1'b0;
    check("ovf_after_clear", 64'(ovf), 64'(0));
    rd_rqst = 1'b1; rd_idx = IDXW'(0);
    step();
    check("preclear_shadow0_7", 64'(rd_data), 64'(7));
    rd_rqst = 1'b0;
    snap_rqst = 1'b1;
    step();
    snap_rqst = 1'b0;
    rd_rqst = 1'b1;
    step();
    check("live0_after_clear_0", 64'(rd_data), 64'(0));
    rd_rqst = 1'b0;
    evt_inc = EW'(1);
    for (int i = 0; i < 3; i++) step();
    ctl_freeze = 1'b1;
    evt_inc    = EW'(3);
    for (int i = 0; i < 4; i++) step();
    snap_rqst = 1'b1;
    step();
    snap_rqst = 1'b0; ctl_freeze = 1'b0; evt_inc = '0;
    rd_rqst = 1'b1; rd_idx = IDXW'(0);
    step();
    check("frozen_cnt0_3", 64'(rd_data), 64'(3));
    rd_rqst = 1'b0;
    read_all();

    // Channel 1 overflow from 254
    ctl_clear = 1'b1;
    step();
    ctl_clear = 1'b0;
    evt_inc[1*INCW +: INCW] = INCW'(2);
    for (int i = 0; i < 127; i++) step();
    evt_inc[1*INCW +: INCW] = INCW'(3);
    step();
    evt_inc   = '0;
    snap_rqst = 1'b1;
    step();
    snap_rqst = 1'b0;
    rd_rqst = 1'b1; rd_idx = IDXW'(1);
    step();
    rd_rqst = 1'b0;
`ifdef STATS_SATURATE_EN
    check("cnt1_saturated", 64'(rd_data), 64'(255));
`else
    check("cnt1_wrapped", 64'(rd_data), 64'(1));
`endif
    check("ovf1_set", 64'(ovf[1]), 64'(1));

    // Randomized phase
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      evt_inc    = EW'($urandom);
      ctl_clear  = ($urandom_range(0, 149) == 0);
      ctl_freeze = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) win_len = WINW'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) hold = !hold;
      snap_rqst = hold;
      rd_rqst   = 1'($urandom_range(0, 1));
      rd_idx    = IDXW'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    win_len = '0;
    for (int i = 0; i < 3; i++) step();

    // Reset while in CAPT with a read in flight
    snap_rqst = 1'b1; rd_rqst = 1'b1; rd_idx = IDXW'(NEVT);
    step();
    check("capt_snap_done", 64'(snap_done), 64'(1));
    snap_rqst = 1'b0; rd_rqst = 1'b0;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk);
    #1;
    check("rst_no_snap_done", 64'(snap_done), 64'(0));
    rst = 1'b0;
    model_reset();

    // Reset arriving before the edge that would have captured
    snap_rqst = 1'b1;
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_abort_snap", 64'(snap_done), 64'(0));
    rst = 1'b0;
    snap_rqst = 1'b0;
    model_reset();
    read_all();
    for (int i = 0; i < 3; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
